// File: rtl/aq_axi_pkg.sv
// -----------------------------------------------------------------------------
// aq_axi_pkg
// Shared definitions for the aq AXI4-Lite initiator: response codes, the
// transaction FSM state type and the fixed PROT/CACHE attributes driven on
// every address channel.
// -----------------------------------------------------------------------------
package aq_axi_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Unprivileged, secure, data access; normal non-cacheable bufferable.
    localparam logic [2:0] AXI_PROT_DEFAULT  = 3'b000;
    localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_DATA,
        ST_DONE
    } axi_state_e;

    // AXI4-Lite has no exclusive access, so anything but OKAY is an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        case (resp)
            AXI_RESP_OKAY:   resp_is_err = 1'b0;
            AXI_RESP_EXOKAY: resp_is_err = 1'b1;
            AXI_RESP_SLVERR: resp_is_err = 1'b1;
            AXI_RESP_DECERR: resp_is_err = 1'b1;
            default:         resp_is_err = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/aq_axi_timeout.sv
// -----------------------------------------------------------------------------
// aq_axi_timeout
// Per-transaction hang timer. Cleared by load_i, counts while en_i is high and
// saturates at TIMEOUT_CYCLES-1. expire_o flags the cycle in which the count
// reaches that value, so the owner leaves its wait state exactly
// TIMEOUT_CYCLES cycles after the first counted cycle. TIMEOUT_CYCLES=0
// disables expiry.
// Ports: clk_i, rst_ni (async, active-low), load_i, en_i, expire_o.
// -----------------------------------------------------------------------------
module aq_axi_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = '0;
        else if (en_i && (cnt_q != LAST))
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign expire_o = (TIMEOUT_CYCLES != 0) && en_i && (cnt_q == LAST);

endmodule

// File: rtl/aq_axi_lite_master.sv
// -----------------------------------------------------------------------------
// aq_axi_lite_master
// AXI4-Lite initiator: converts one local-bus request into a single AXI4-Lite
// read or write, with one transaction outstanding and a bus-hang timeout.
// Ports:
//   ARESETN/ACLK            async active-low reset, clock
//   LOCAL_CS/RNW/ADDR/BE/WDATA  request (sampled in IDLE only)
//   LOCAL_ACK/RDATA/ERR, BUSY   completion pulse, read data, error, busy
//   M_AXI_AW*/W*/B*/AR*/R*  AXI4-Lite master channels
// All AXI VALID/READY and local status outputs are decoded from registered
// state only, so there is no combinational path from any input to them.
// -----------------------------------------------------------------------------
module aq_axi_lite_master
    import aq_axi_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  ARESETN,
    input  logic                  ACLK,
    input  logic                  LOCAL_CS,
    input  logic                  LOCAL_RNW,
    input  logic [ADDR_WIDTH-1:0] LOCAL_ADDR,
    input  logic [3:0]            LOCAL_BE,
    input  logic [31:0]           LOCAL_WDATA,
    output logic                  LOCAL_ACK,
    output logic [31:0]           LOCAL_RDATA,
    output logic                  LOCAL_ERR,
    output logic                  BUSY,
    output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [2:0]            M_AXI_AWPROT,
    output logic [3:0]            M_AXI_AWCACHE,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [31:0]           M_AXI_WDATA,
    output logic [3:0]            M_AXI_WSTRB,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    input  logic                  M_AXI_BVALID,
    input  logic [1:0]            M_AXI_BRESP,
    output logic                  M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [2:0]            M_AXI_ARPROT,
    output logic [3:0]            M_AXI_ARCACHE,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    input  logic [31:0]           M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY
);

    axi_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            be_q, be_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic                  err_q, err_d;
    logic                  tmr_load, tmr_en, tmr_expire;
    logic                  aw_hs, w_hs;

    assign aw_hs  = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs   = M_AXI_WVALID  && M_AXI_WREADY;
    assign tmr_en = (state_q != ST_IDLE) && (state_q != ST_DONE);

    aq_axi_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk_i    (ACLK),
        .rst_ni   (ARESETN),
        .load_i   (tmr_load),
        .en_i     (tmr_en),
        .expire_o (tmr_expire)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        err_d     = err_q;
        tmr_load  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (LOCAL_CS) begin
                    addr_d    = LOCAL_ADDR;
                    be_d      = LOCAL_BE;
                    wdata_d   = LOCAL_WDATA;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    err_d     = 1'b0;
                    tmr_load  = 1'b1;
                    state_d   = LOCAL_RNW ? ST_RD_REQ : ST_WR_REQ;
                end
            end
            ST_WR_REQ: begin
                // AW and W complete independently; advance once both are in.
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs))
                    state_d = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                if (M_AXI_BVALID) begin
                    err_d   = resp_is_err(M_AXI_BRESP);
                    state_d = ST_DONE;
                end
            end
            ST_RD_REQ: begin
                if (M_AXI_ARREADY) state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                if (M_AXI_RVALID) begin
                    rdata_d = M_AXI_RDATA;
                    err_d   = resp_is_err(M_AXI_RRESP);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Timeout overrides whatever the wait state was doing; read data is
        // left as it was so a hung read never reports stale bus contents.
        if (tmr_expire) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
            rdata_d = rdata_q;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            err_q     <= err_d;
        end
    end

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = AXI_PROT_DEFAULT;
    assign M_AXI_AWCACHE = AXI_CACHE_DEFAULT;
    assign M_AXI_AWVALID = (state_q == ST_WR_REQ) && !aw_done_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = be_q;
    assign M_AXI_WVALID  = (state_q == ST_WR_REQ) && !w_done_q;
    assign M_AXI_BREADY  = (state_q == ST_WR_RESP);
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = AXI_PROT_DEFAULT;
    assign M_AXI_ARCACHE = AXI_CACHE_DEFAULT;
    assign M_AXI_ARVALID = (state_q == ST_RD_REQ);
    assign M_AXI_RREADY  = (state_q == ST_RD_DATA);

    assign LOCAL_ACK   = (state_q == ST_DONE);
    assign LOCAL_ERR   = (state_q == ST_DONE) && err_q;
    assign LOCAL_RDATA = rdata_q;
    assign BUSY        = (state_q != ST_IDLE);

endmodule
